// File: rtl/trace_trig_pkg.sv
// ---------------------------------------------------------------------------
// trace_trig_pkg
// Shared definitions for the trace trigger sequencer:
//   - trig_state_t : sequencer state encoding
//   - DEF_MASK_SLICE_W   : default width of one per-step source mask slice
//   - DEF_WINDOW_SLICE_W : default width of one per-step window slice
//   - DEF_STEPS          : default maximum sequence depth
//   - slice_lo()         : low bit index of slice k in a flattened bus
// ---------------------------------------------------------------------------
package trace_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DELAY = 3'd2,
    ST_PULSE = 3'd3,
    ST_DONE  = 3'd4
  } trig_state_t;

  localparam int DEF_MASK_SLICE_W   = 8;
  localparam int DEF_WINDOW_SLICE_W = 16;
  localparam int DEF_STEPS          = 4;

  // Per-step configuration is packed as consecutive equal-width slices,
  // step 0 in the least significant bits.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/trig_pulse_timer.sv
// ---------------------------------------------------------------------------
// trig_pulse_timer
// Loadable down-counter with a zero flag. The sequencer reuses one instance
// for both the post-match delay and the output pulse length.
//
// Ports:
//   fe_clk      in  clock, rising edge
//   reset_n     in  asynchronous active-low reset (count cleared)
//   load        in  load load_value this cycle (wins over dec)
//   load_value  in  value to load
//   dec         in  decrement by one; holds once zero
//   zero        out count is zero
// ---------------------------------------------------------------------------
module trig_pulse_timer #(
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [pCOUNT_WIDTH-1:0] load_value,
  input  logic                    dec,
  output logic                    zero
);

  localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE = 1;

  logic [pCOUNT_WIDTH-1:0] count;

  // A load always takes precedence so the sequencer can reload the timer on
  // the same edge it finishes the delay phase. Decrementing saturates at zero
  // so a stray dec never wraps the counter.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - CNT_ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/trace_trig_sequencer.sv
// ---------------------------------------------------------------------------
// trace_trig_sequencer
// Multi-step trigger sequencer. Once armed it walks through up to pSTEPS
// match steps; each step matches when any source enabled in that step's
// mask pulses. After the final step it waits I_delay cycles and then drives
// a registered trigger pulse of max(I_width,1) cycles.
//
// Optional feature macro: TRIG_SEQ_TIMEOUT_EN
//   When defined, the I_window port exists and each step has a timeout; a
//   step that sees no match within window[step] cycles sends the sequence
//   back to step 0 (window 0 disables the timeout for that step).
//
// Ports:
//   fe_clk       in  clock, rising edge
//   reset_n      in  asynchronous active-low reset
//   I_arm        in  level arm request
//   I_source     in  trigger source pulses
//   I_step_mask  in  per-step source OR-masks, step k in slice k
//   I_num_steps  in  active step count (0 treated as 1, clamped to pSTEPS)
//   I_delay      in  cycles between final match and pulse
//   I_width      in  pulse length (0 treated as 1)
//   I_window     in  per-step timeout (TRIG_SEQ_TIMEOUT_EN only)
//   O_trig_out   out registered trigger pulse
//   O_armed      out high in WAIT and DELAY
//   O_capturing  out high in PULSE
//   O_done       out high in DONE
//   O_step       out current step index
// ---------------------------------------------------------------------------
module trace_trig_sequencer
  import trace_trig_pkg::*;
#(
  parameter int pNUM_SOURCES = DEF_MASK_SLICE_W,
  parameter int pSTEPS       = DEF_STEPS,
  parameter int pCOUNT_WIDTH = DEF_WINDOW_SLICE_W
) (
  input  logic                             fe_clk,
  input  logic                             reset_n,
  input  logic                             I_arm,
  input  logic [pNUM_SOURCES-1:0]          I_source,
  input  logic [pSTEPS*pNUM_SOURCES-1:0]   I_step_mask,
  input  logic [$clog2(pSTEPS):0]          I_num_steps,
  input  logic [pCOUNT_WIDTH-1:0]          I_delay,
  input  logic [pCOUNT_WIDTH-1:0]          I_width,
`ifdef TRIG_SEQ_TIMEOUT_EN
  input  logic [pSTEPS*pCOUNT_WIDTH-1:0]   I_window,
`endif
  output logic                             O_trig_out,
  output logic                             O_armed,
  output logic                             O_capturing,
  output logic                             O_done,
  output logic [$clog2(pSTEPS)-1:0]        O_step
);

  localparam int STEP_W = $clog2(pSTEPS);
  localparam logic [STEP_W-1:0]       STEP_ONE = 1;
  localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE  = 1;

  trig_state_t             state;
  trig_state_t             next_state;
  logic [STEP_W-1:0]       step;
  logic [STEP_W-1:0]       step_next;
  logic [STEP_W-1:0]       final_step;
  logic [pNUM_SOURCES-1:0] cur_mask;
  logic                    step_match;
  logic                    trig_q;
  logic                    timer_load;
  logic [pCOUNT_WIDTH-1:0] timer_value;
  logic                    timer_dec;
  logic                    timer_zero;
  logic [pCOUNT_WIDTH-1:0] delay_load;
  logic [pCOUNT_WIDTH-1:0] width_load;

  // The last step index is the programmed step count clamped into 1..pSTEPS,
  // minus one, so a zero or oversized count still gives a usable sequence.
  always_comb begin
    final_step = '0;
    if (I_num_steps == '0) begin
      final_step = '0;
    end else if (int'(I_num_steps) >= pSTEPS) begin
      final_step = STEP_W'(pSTEPS - 1);
    end else begin
      final_step = STEP_W'(I_num_steps - 1'b1);
    end
  end

  // Pick out the mask slice for the current step. An all-zero slice can never
  // produce a match, which is how a step is effectively disabled.
  always_comb begin
    cur_mask = '0;
    for (int k = 0; k < pSTEPS; k++) begin
      if (int'(step) == k) begin
        cur_mask = I_step_mask[slice_lo(k, pNUM_SOURCES) +: pNUM_SOURCES];
      end
    end
  end

  assign step_match = |(I_source & cur_mask);

  // The timer is loaded with length-1 because the cycle spent at zero is
  // itself the last cycle of the phase. A zero width still yields one cycle.
  assign delay_load = I_delay - CNT_ONE;
  assign width_load = (I_width == '0) ? '0 : (I_width - CNT_ONE);

`ifdef TRIG_SEQ_TIMEOUT_EN
  logic [pCOUNT_WIDTH-1:0] cur_window;
  logic [pCOUNT_WIDTH-1:0] win_cnt;
  logic                    win_expired;

  // Window slice for the current step, same packing as the masks.
  always_comb begin
    cur_window = '0;
    for (int k = 0; k < pSTEPS; k++) begin
      if (int'(step) == k) begin
        cur_window = I_window[slice_lo(k, pCOUNT_WIDTH) +: pCOUNT_WIDTH];
      end
    end
  end

  assign win_expired = (state == ST_WAIT) && (cur_window != '0) &&
                       (win_cnt == (cur_window - CNT_ONE));

  // Counts unmatched cycles spent on the current step. It restarts whenever
  // the step changes (match or timeout) and is idle outside WAIT.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt <= '0;
    end else if ((state != ST_WAIT) || step_match || win_expired) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + CNT_ONE;
    end
  end
`endif

  // State register.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, step and timer control, plus the state-decoded status
  // outputs. Dropping I_arm aborts while still waiting or delaying, but a
  // pulse that has started always runs to its full width. A match on the
  // same cycle as a timeout wins, since the timeout branch is only reached
  // when there is no match.
  always_comb begin
    next_state  = state;
    step_next   = step;
    timer_load  = 1'b0;
    timer_value = '0;
    timer_dec   = 1'b0;
    O_armed     = 1'b0;
    O_capturing = 1'b0;
    O_done      = 1'b0;

    case (state)
      ST_IDLE: begin
        step_next = '0;
        if (I_arm) begin
          next_state = ST_WAIT;
        end
      end

      ST_WAIT: begin
        O_armed = 1'b1;
        if (!I_arm) begin
          next_state = ST_IDLE;
          step_next  = '0;
        end else if (step_match) begin
          if (step >= final_step) begin
            timer_load = 1'b1;
            if (I_delay == '0) begin
              next_state  = ST_PULSE;
              timer_value = width_load;
            end else begin
              next_state  = ST_DELAY;
              timer_value = delay_load;
            end
          end else begin
            step_next = step + STEP_ONE;
          end
        end
`ifdef TRIG_SEQ_TIMEOUT_EN
        else if (win_expired) begin
          step_next = '0;
        end
`endif
      end

      ST_DELAY: begin
        O_armed = 1'b1;
        if (!I_arm) begin
          next_state = ST_IDLE;
          step_next  = '0;
        end else if (timer_zero) begin
          next_state  = ST_PULSE;
          timer_load  = 1'b1;
          timer_value = width_load;
        end else begin
          timer_dec = 1'b1;
        end
      end

      ST_PULSE: begin
        O_capturing = 1'b1;
        if (timer_zero) begin
          next_state = ST_DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      ST_DONE: begin
        O_done = 1'b1;
        if (!I_arm) begin
          next_state = ST_IDLE;
          step_next  = '0;
        end
      end

      default: begin
        next_state = ST_IDLE;
        step_next  = '0;
      end
    endcase
  end

  // Step index and the trigger output. The trigger follows the PULSE state
  // one cycle later, which gives the one-cycle gap between the final match
  // and the first high cycle even with zero delay.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      step   <= '0;
      trig_q <= 1'b0;
    end else begin
      step   <= step_next;
      trig_q <= (state == ST_PULSE);
    end
  end

  trig_pulse_timer #(
    .pCOUNT_WIDTH(pCOUNT_WIDTH)
  ) u_timer (
    .fe_clk    (fe_clk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .load_value(timer_value),
    .dec       (timer_dec),
    .zero      (timer_zero)
  );

  assign O_trig_out = trig_q;
  assign O_step     = step;

endmodule

// File: tb/tb_trace_trig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trace_trig_sequencer
// Directed bench for trace_trig_sequencer with default parameters
// (8 sources, 4 steps, 16-bit counters). The per-step timeout scenario is
// only built when TRIG_SEQ_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_trace_trig_sequencer;

  logic        fe_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        I_arm = 1'b0;
  logic [7:0]  I_source = '0;
  logic [31:0] I_step_mask = '0;
  logic [2:0]  I_num_steps = '0;
  logic [15:0] I_delay = '0;
  logic [15:0] I_width = '0;
`ifdef TRIG_SEQ_TIMEOUT_EN
  logic [63:0] I_window = '0;
`endif
  logic        O_trig_out;
  logic        O_armed;
  logic        O_capturing;
  logic        O_done;
  logic [1:0]  O_step;

  int check_count = 0;
  int fail_count  = 0;

  trace_trig_sequencer #(
    .pNUM_SOURCES(8),
    .pSTEPS      (4),
    .pCOUNT_WIDTH(16)
  ) dut (
    .fe_clk     (fe_clk),
    .reset_n    (reset_n),
    .I_arm      (I_arm),
    .I_source   (I_source),
    .I_step_mask(I_step_mask),
    .I_num_steps(I_num_steps),
    .I_delay    (I_delay),
    .I_width    (I_width),
`ifdef TRIG_SEQ_TIMEOUT_EN
    .I_window   (I_window),
`endif
    .O_trig_out (O_trig_out),
    .O_armed    (O_armed),
    .O_capturing(O_capturing),
    .O_done     (O_done),
    .O_step     (O_step)
  );

  // 10-time-unit clock, rising edges at 5, 15, 25, ...
  always #5 fe_clk = ~fe_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, well away from the edge.
  task automatic stepCycle();
    @(posedge fe_clk);
    #1;
  endtask

  // Present a source pattern for exactly one sampling edge.
  task automatic applyStimulus(input logic [7:0] src);
    I_source = src;
    stepCycle();
    I_source = '0;
  endtask

  task automatic configure(input logic [2:0] steps, input logic [31:0] masks,
                           input logic [15:0] delay, input logic [15:0] width);
    I_num_steps = steps;
    I_step_mask = masks;
    I_delay     = delay;
    I_width     = width;
  endtask

  // All outputs at their idle/reset values: {trig, armed, capturing, done, step}.
  task automatic checkIdle(input string tag);
    checkOutput(tag, {26'd0, O_trig_out, O_armed, O_capturing, O_done, O_step}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int done_seen;

    // Reset held, then released between clock edges.
    #3;
    checkIdle("reset_hold");
    #9 reset_n = 1'b1;
    stepCycle();
    checkIdle("post_reset");

    // Single step, zero delay, width 3: match at edge N -> high at N+1..N+3.
    $display("[TB] single step, width 3");
    configure(3'd1, 32'h0000_0001, 16'd0, 16'd3);
    I_arm = 1'b1;
    stepCycle();
    checkOutput("t1_armed", O_armed, 1'b1);
    checkOutput("t1_step0", O_step, 2'd0);
    stepCycle();
    stepCycle();
    checkOutput("t1_wait_quiet", O_trig_out, 1'b0);
    applyStimulus(8'h01);
    checkOutput("t1_latency", O_trig_out, 1'b0);
    checkOutput("t1_capturing", O_capturing, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("t1_pulse", O_trig_out, 1'b1);
    end
    stepCycle();
    checkOutput("t1_pulse_end", O_trig_out, 1'b0);
    checkOutput("t1_done", O_done, 1'b1);
    I_arm = 1'b0;
    stepCycle();
    checkIdle("t1_disarm");

    // An all-zero mask never matches, even with every source active.
    $display("[TB] zero mask");
    configure(3'd1, 32'h0000_0000, 16'd0, 16'd1);
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'hFF);
    stepCycle();
    checkOutput("zmask_hold", {O_armed, O_capturing, O_trig_out}, 3'b100);
    I_arm = 1'b0;
    stepCycle();
    checkIdle("zmask_disarm");

    // Three steps; an out-of-order source is ignored, only the last fires.
    $display("[TB] three-step sequence");
    configure(3'd3, 32'h0004_0201, 16'd0, 16'd1);
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'h02);
    checkOutput("t2_wrong_src", O_step, 2'd0);
    applyStimulus(8'h01);
    checkOutput("t2_step1", O_step, 2'd1);
    applyStimulus(8'h02);
    checkOutput("t2_step2", O_step, 2'd2);
    checkOutput("t2_no_early_fire", {O_armed, O_trig_out}, 2'b10);
    applyStimulus(8'h04);
    checkOutput("t2_fire", O_capturing, 1'b1);
    stepCycle();
    checkOutput("t2_pulse", O_trig_out, 1'b1);
    stepCycle();
    checkOutput("t2_pulse_end", {O_trig_out, O_done}, 2'b01);
    I_arm = 1'b0;
    stepCycle();
    checkIdle("t2_disarm");

    // Delay 5, width 0: match at edge N -> one-cycle pulse at N+6.
    $display("[TB] delay 5, width 0");
    configure(3'd1, 32'h0000_0001, 16'd5, 16'd0);
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'h01);
    checkOutput("t3_delay_state", {O_armed, O_capturing}, 2'b10);
    for (int i = 1; i <= 5; i++) begin
      stepCycle();
      checkOutput("t3_delay_quiet", O_trig_out, 1'b0);
    end
    stepCycle();
    checkOutput("t3_pulse", O_trig_out, 1'b1);
    stepCycle();
    checkOutput("t3_single", {O_trig_out, O_done}, 2'b01);
    I_arm = 1'b0;
    stepCycle();
    checkIdle("t3_disarm");

    // Abort during DELAY: no pulse at all and step back to 0.
    $display("[TB] abort in delay");
    configure(3'd2, 32'h0000_0201, 16'd5, 16'd2);
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkOutput("t4_in_delay", {O_armed, O_step}, 3'b101);
    stepCycle();
    I_arm = 1'b0;
    stepCycle();
    checkIdle("t4_abort");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (O_trig_out) pulses++;
    end
    checkOutput("t4_no_pulse", pulses, 0);

    // Drop arm mid-pulse: the full 4-cycle pulse completes, then DONE, IDLE.
    $display("[TB] disarm during pulse");
    configure(3'd1, 32'h0000_0001, 16'd0, 16'd4);
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'h01);
    stepCycle();
    checkOutput("t4b_pulse_start", O_trig_out, 1'b1);
    I_arm = 1'b0;
    pulses = 1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      if (O_trig_out) pulses++;
      if (O_done) done_seen = 1;
    end
    checkOutput("t4b_full_width", pulses, 4);
    checkOutput("t4b_done_seen", done_seen, 1);
    checkIdle("t4b_idle");

`ifdef TRIG_SEQ_TIMEOUT_EN
    // Window of 4 on step 1: four idle cycles send the step back to 0, but a
    // match on the fourth cycle advances instead.
    $display("[TB] step timeout");
    configure(3'd2, 32'h0000_0201, 16'd0, 16'd1);
    I_window = {16'd0, 16'd0, 16'd4, 16'd0};
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'h01);
    checkOutput("t5_step1", O_step, 2'd1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("t5_window_hold", O_step, 2'd1);
    end
    stepCycle();
    checkOutput("t5_timeout", {O_armed, O_step}, 3'b100);
    applyStimulus(8'h01);
    checkOutput("t5_step1_again", O_step, 2'd1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
    end
    applyStimulus(8'h02);
    checkOutput("t5_match_priority", {O_capturing, O_step}, 3'b101);
    stepCycle();
    checkOutput("t5_pulse", O_trig_out, 1'b1);
    I_arm = 1'b0;
    I_window = '0;
    stepCycle();
    stepCycle();
    checkIdle("t5_disarm");
`endif

    // Asynchronous reset in the middle of a long pulse.
    $display("[TB] reset mid-pulse");
    configure(3'd2, 32'h0000_0201, 16'd0, 16'd10);
    I_arm = 1'b1;
    stepCycle();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    stepCycle();
    checkOutput("t6_pulse_on", {O_trig_out, O_step}, 3'b101);
    #2 reset_n = 1'b0;
    #1;
    checkIdle("t6_async_reset");
    stepCycle();
    checkIdle("t6_reset_held");
    I_arm = 1'b0;
    reset_n = 1'b1;
    stepCycle();
    checkIdle("t6_after_release");

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/trace_trig_sequencer.md
TRACE_TRIG_SEQUENCER -- requirements
Module: trace_trig_sequencer

Interface
REQ-001 SHALL have parameter pNUM_SOURCES, default 8: number of trigger source lines (match rules, m3_trig, userio).
REQ-002 SHALL have parameter pSTEPS, default 4: maximum sequence depth.
REQ-003 SHALL have parameter pCOUNT_WIDTH, default 16: width of the delay, width and window counters.
REQ-004 SHALL have port fe_clk  input  1: sole clock. One clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port I_arm  input  1: level arm request.
REQ-007 SHALL have port I_source  input  pNUM_SOURCES: trigger pulses, synchronous to fe_clk.
REQ-008 SHALL have port I_step_mask  input  pSTEPS*pNUM_SOURCES: per-step source OR-mask; step k uses slice k.
REQ-009 SHALL have port I_num_steps  input  $clog2(pSTEPS)+1: active step count.
REQ-010 SHALL have port I_delay  input  pCOUNT_WIDTH: cycles from final match to pulse.
REQ-011 SHALL have port I_width  input  pCOUNT_WIDTH: pulse length in cycles.
REQ-012 SHALL have port I_window  input  pSTEPS*pCOUNT_WIDTH: per-step timeout; present only with the macro (REQ-028).
REQ-013 SHALL have port O_trig_out  output  1: registered trigger pulse.
REQ-014 SHALL have port O_armed  output  1: high in WAIT and DELAY.
REQ-015 SHALL have port O_capturing  output  1: high in PULSE.
REQ-016 SHALL have port O_done  output  1: high in DONE.
REQ-017 SHALL have port O_step  output  $clog2(pSTEPS): current step index.

Function
REQ-018 SHALL implement states IDLE, WAIT, DELAY, PULSE and DONE.
REQ-019 IDLE SHALL move to WAIT with step=0 on the first cycle I_arm=1.
REQ-020 WAIT SHALL treat a step as matched when (I_source & mask[step]) != 0; an all-zero mask SHALL never match.
REQ-021 On a match at a non-final step, WAIT SHALL increment step; on a match at the final step it SHALL enter DELAY, or PULSE directly if I_delay=0.
REQ-022 Final step index SHALL be min(max(I_num_steps,1),pSTEPS)-1.
REQ-023 Timing SHALL be: final match sampled at edge N gives O_trig_out high from edge N+1+I_delay, for max(I_width,1) cycles.
REQ-024 After PULSE the block SHALL enter DONE and remain there until I_arm=0, then return to IDLE.
REQ-025 I_arm=0 in WAIT or DELAY SHALL abort to IDLE on the next edge with step=0; in PULSE the pulse SHALL complete, then DONE.
REQ-026 Configuration inputs SHALL be sampled live; changing them outside IDLE is the user's responsibility, and no latching is done.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, step=0, all counters 0, O_trig_out=0, O_armed=0, O_capturing=0, O_done=0, O_step=0, including mid-pulse.

Configuration
REQ-028 Macro TRIG_SEQ_TIMEOUT_EN: when defined, I_window exists and a window counter runs in WAIT, reset on each step advance.
REQ-029 With TRIG_SEQ_TIMEOUT_EN, window[step]!=0 with no match for window[step] cycles SHALL reset step to 0 and stay in WAIT; window[step]=0 SHALL mean no timeout.
REQ-030 With TRIG_SEQ_TIMEOUT_EN, a timeout and a match on the same cycle SHALL give the match priority.
REQ-031 Without TRIG_SEQ_TIMEOUT_EN, there SHALL be no port, no counter and no timeout; WAIT holds indefinitely.

Structure
REQ-032 Package trace_trig_pkg SHALL hold the state encodings and the mask/window slice-width constants.
REQ-033 Sub-module trig_pulse_timer SHALL be used: a loadable pCOUNT_WIDTH down-counter with a zero flag, shared by DELAY and PULSE.

Verification
REQ-034 Steps=1, mask0=0x01, delay=0, width=3; I_source=0x01 at edge 10 -> O_trig_out high at edges 11-13, then O_done=1.
REQ-035 Steps=3, masks 0x01/0x02/0x04; pulse 0x02 first, then 0x01, 0x02, 0x04 -> only the 0x04 pulse fires; O_step reads 0,1,2.
REQ-036 Delay=5, width=0; match at edge 20 -> single-cycle pulse at edge 26.
REQ-037 Drop I_arm during DELAY -> no pulse, back to IDLE, O_step=0; drop I_arm mid-PULSE -> full width, then DONE, then IDLE.
REQ-038 With TRIG_SEQ_TIMEOUT_EN, steps=2, window1=4; step0 match, then no source for 4 cycles -> O_step back to 0; a match on cycle 4 advances instead.
REQ-039 Assert reset_n=0 mid-pulse -> O_trig_out=0 immediately and all outputs at reset values.
